// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer: command
// opcodes, USR mode-select values and the controller state set.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_SHR_LOG = 3'b001,
    OP_SHL_LOG = 3'b010,
    OP_SHR_ARI = 3'b011,
    OP_ROR     = 3'b100,
    OP_ROL     = 3'b101,
    OP_SHR_SER = 3'b110,
    OP_SHL_SER = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_HOLD = 2'b00,
    S_SHR  = 2'b01,
    S_SHL  = 2'b10,
    S_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Right-moving ops feed the fill bit in at the MSB and shed Q[0].
  function automatic logic is_right(input op_e op);
    return op inside {OP_SHR_LOG, OP_SHR_ARI, OP_ROR, OP_SHR_SER};
  endfunction

endpackage

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// selected by s each clock.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         MSB_in,
  input  logic         LSB_in,
  input  logic [n-1:0] I,
  input  logic [1:0]   s,
  output logic [n-1:0] Q
);

  // Register update according to the mode select.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q <= '0;
    end else begin
      case (s)
        S_SHR:   Q <= {MSB_in, Q[n-1:1]};
        S_SHL:   Q <= {Q[n-2:0], LSB_in};
        S_LOAD:  Q <= I;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven controller for one universal shift register. A command
// {op, count, data} is accepted on a valid/ready handshake; the FSM then
// drives the USR mode, parallel word and fill bits until the result is final
// and pulses done.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [CW-1:0] cmd_count,
  input  logic [N-1:0]  cmd_data,
  input  logic          ser_in,
  input  logic          abort,
  output logic          shift_en,
  output logic          ser_out,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  data_out
);

  state_e        state, state_next;
  op_e           op_q;
  logic [CW-1:0] remaining;
  logic [N-1:0]  data_q;
  mode_e         mode;
  logic          msb_in, lsb_in;
  logic          fill;
  logic          accept;

  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state != ST_IDLE);

  // State register plus latched command and remaining-shift counter.
  // NOTE: the latched data word is reset along with the control state; it is a single register, not a memory array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_LOAD;
      remaining <= '0;
      data_q    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q      <= op_e'(cmd_op);
        remaining <= cmd_count;
        data_q    <= cmd_data;
      end else if (shift_en) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

  // Fill bit entering the register for the latched op, taken from current Q.
  always_comb begin
    fill = 1'b0;
    case (op_q)
      OP_SHR_ARI: fill = data_out[N-1];
      OP_ROR:     fill = data_out[0];
      OP_ROL:     fill = data_out[N-1];
      OP_SHR_SER: fill = ser_in;
      OP_SHL_SER: fill = ser_in;
      default:    fill = 1'b0;
    endcase
  end

  // Next-state logic and datapath control outputs.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    mode       = S_HOLD;
    shift_en   = 1'b0;
    done       = 1'b0;
    msb_in     = 1'b0;
    lsb_in     = 1'b0;
    ser_out    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD)   state_next = ST_LOAD;
          else if (cmd_count == '0) state_next = ST_DONE;
          else                      state_next = ST_SHIFT;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          mode       = S_LOAD;
          state_next = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          if (is_right(op_q)) begin
            mode    = S_SHR;
            msb_in  = fill;
            ser_out = data_out[0];
          end else begin
            mode    = S_SHL;
            lsb_in  = fill;
            ser_out = data_out[N-1];
          end
          if (remaining == CW'(1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  universal_shift_register #(.n(N)) u_usr (
    .clk     (clk),
    .reset_n (reset_n),
    .MSB_in  (msb_in),
    .LSB_in  (lsb_in),
    .I       (data_q),
    .s       (mode),
    .Q       (data_out)
  );

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer (N=4): directed cases followed
// by random commands, checked against a closed-form reference model.
module tb_usr_shift_sequencer;
  import usr_pkg::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N) + 1;
  localparam int MASK = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [N-1:0]  cmd_data;
  logic          ser_in;
  logic          abort;
  logic          shift_en;
  logic          ser_out;
  logic          busy;
  logic          done;
  logic [N-1:0]  data_out;

  int n_vec = 0;
  int n_err = 0;
  int model_q = 0;

  usr_shift_sequencer #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .abort     (abort),
    .shift_en  (shift_en),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit op_is_right(input int op);
    return (op == 1) || (op == 3) || (op == 4) || (op == 6);
  endfunction

  // Register contents after j shifts of op applied to q0, ser bit i used by shift i+1.
  function automatic int q_after(input int op, input int q0, input int ser, input int j);
    int r, v, rev;
    r = j % N;
    case (op)
      1: v = q0 >> j;
      2: v = q0 << j;
      3: v = ((q0 >= (1 << (N - 1))) ? q0 - (1 << N) : q0) >>> j;
      4: v = (q0 >> r) | (q0 << (N - r));
      5: v = (q0 << r) | (q0 >> (N - r));
      6: v = (q0 | ((ser & ((1 << j) - 1)) << N)) >> j;
      7: begin
        rev = 0;
        for (int i = 0; i < j; i++) rev |= ((ser >> i) & 1) << (j - 1 - i);
        v = (q0 << j) | rev;
      end
      default: v = q0;
    endcase
    return v & MASK;
  endfunction

  // Issue one command from an IDLE negedge; returns on the next IDLE negedge.
  task automatic run_cmd(input int op, input int count, input int data, input int ser, input int abort_k);
    int m, q0, qb;
    q0 = model_q;
    m  = (op == 0) ? 1 : count;
    check("idle_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_count = CW'(count);
    cmd_data  = N'(data);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_count = CW'($urandom);
    cmd_data  = N'($urandom);
    for (int k = 1; k <= m + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= m) begin
        check("busy", 32'(busy), 1);
        check("ready_busy", 32'(cmd_ready), 0);
        check("done_early", 32'(done), 0);
        if (op == 0) begin
          check("load_shift_en", 32'(shift_en), 0);
        end else begin
          qb = q_after(op, q0, ser, k - 1);
          check("data_mid", 32'(data_out), qb);
          check("shift_en", 32'(shift_en), 1);
          check("ser_out", 32'(ser_out), op_is_right(op) ? (qb & 1) : ((qb >> (N - 1)) & 1));
          ser_in = 1'((ser >> (k - 1)) & 1);
        end
        if (k == abort_k) begin
          abort = 1'b1;
          #1;
          check("abort_shift_en", 32'(shift_en), 0);
          @(negedge clk);
          abort = 1'b0;
          model_q = (op == 0) ? q0 : q_after(op, q0, ser, k - 1);
          check("abort_idle", 32'(busy), 0);
          check("abort_ready", 32'(cmd_ready), 1);
          check("abort_no_done", 32'(done), 0);
          check("abort_q", 32'(data_out), model_q);
          return;
        end
      end else begin
        model_q = (op == 0) ? (data & MASK) : q_after(op, q0, ser, count);
        check("done", 32'(done), 1);
        check("done_shift_en", 32'(shift_en), 0);
        check("result", 32'(data_out), model_q);
        abort = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    abort = 1'b0;
    check("done_pulse", 32'(done), 0);
    check("back_idle", 32'(busy), 0);
    check("hold_q", 32'(data_out), model_q);
  endtask

  initial begin
    int op, cnt, m, ak;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0;
    cmd_data = '0; ser_in = 1'b0; abort = 1'b0;
    #1;
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_shift_en", 32'(shift_en), 0);
    check("rst_q", 32'(data_out), 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_cmd(0, 0, 4'b0010, 0, 0);
    check("ex_load", 32'(data_out), 4'b0010);
    run_cmd(0, 0, 4'b1011, 0, 0);
    run_cmd(1, 2, 0, 0, 0);
    check("ex_shr_log", 32'(data_out), 4'b0010);
    run_cmd(0, 0, 4'b1000, 0, 0);
    run_cmd(3, 3, 0, 0, 0);
    check("ex_shr_ari", 32'(data_out), 4'b1111);
    run_cmd(0, 0, 4'b1000, 0, 0);
    run_cmd(5, 5, 0, 0, 0);
    check("ex_rol5", 32'(data_out), 4'b0001);
    run_cmd(0, 0, 4'b0000, 0, 0);
    run_cmd(7, 4, 0, 4'b1101, 0);
    check("ex_shl_ser", 32'(data_out), 4'b1011);
    run_cmd(1, 0, 0, 0, 0);
    check("ex_count0", 32'(data_out), 4'b1011);
    run_cmd(0, 0, 4'b0001, 0, 0);
    run_cmd(4, 4, 0, 0, 2);
    check("ex_abort", 32'(data_out), 4'b1000);

    // Command held valid while busy is taken only on the first IDLE cycle.
    run_cmd(0, 0, 4'b0110, 0, 0);
    cmd_valid = 1'b1; cmd_op = 3'(OP_SHR_LOG); cmd_count = CW'(2); cmd_data = '0;
    @(negedge clk);
    cmd_op = 3'(OP_LOAD); cmd_count = '0; cmd_data = 4'b1001;
    check("held_busy1", 32'(cmd_ready), 0);
    @(negedge clk);
    check("held_busy2", 32'(cmd_ready), 0);
    @(negedge clk);
    check("held_done", 32'(done), 1);
    check("held_first_q", 32'(data_out), 4'b0001);
    check("held_ready_done", 32'(cmd_ready), 0);
    @(negedge clk);
    check("held_idle_ready", 32'(cmd_ready), 1);
    check("held_idle_busy", 32'(busy), 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_accepted", 32'(busy), 1);
    @(negedge clk);
    check("held_second_done", 32'(done), 1);
    check("held_second_q", 32'(data_out), 4'b1001);
    @(negedge clk);
    model_q = 4'b1001;

    // Reset mid-operation clears everything without a clock edge.
    cmd_valid = 1'b1; cmd_op = 3'(OP_SHL_LOG); cmd_count = CW'(5);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_q", 32'(data_out), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(cmd_ready), 1);
    check("midrst_shift_en", 32'(shift_en), 0);
    check("midrst_done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_q = 0;
    @(negedge clk);

    // Random commands.
    for (int t = 0; t < 80; t++) begin
      op  = $urandom_range(0, 7);
      cnt = $urandom_range(0, (1 << CW) - 1);
      m   = (op == 0) ? 1 : cnt;
      ak  = (m > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, m) : 0;
      run_cmd(op, cnt, $urandom_range(0, MASK), $urandom, ak);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
